aes_inv_rounds: RTL and testbench
=================================

AES_INV_ROUNDS -- requirements
Module: aes_inv_rounds

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 128 bits (AES-128).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high, ports named clock and reset.
REQ-003 Port `clock`: input, 1 bit, rising-edge clock for all state.
REQ-004 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-005 Port `start`: input, 1 bit, request to decrypt `ciphertext` under `lastkey`; sampled on the rising edge.
REQ-006 Port `ciphertext`: input, 128 bits, cipher block; bits [127:120] = byte 0 (FIPS-197 column-major order).
REQ-007 Port `lastkey`: input, 128 bits, round-10 key of the AES-128 schedule, same byte order.
REQ-008 Port `busy`: output, 1 bit, high while a decryption is in progress.
REQ-009 Port `done`: output, 1 bit, one-cycle pulse marking a new result.
REQ-010 Port `plaintext`: output, 128 bits, registered decryption result.
REQ-011 Port `keyoutput`: output, 128 bits, registered recovered cipher key (round-0 key).

Function
REQ-012 The block SHALL be an iterative FIPS-197 inverse cipher performing one inverse round per clock.
REQ-013 The block SHALL derive round keys on the fly by reverse key expansion from `lastkey`; no key storage beyond one 128-bit register.
REQ-014 Reverse step k(i) -> k(i-1), words w0..w3:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(i).
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte.
REQ-015 The FSM SHALL have two states, IDLE and RUN, plus a 4-bit round counter.
REQ-016 IDLE, start=1 (accept edge):
  - state <= ciphertext ^ lastkey; key <= lastkey; counter <= 10.
  - go to RUN; busy=1 from the next cycle.
REQ-017 In RUN, each edge with counter=r SHALL compute key k(r-1) per REQ-014.
REQ-018 In RUN, for r=10..2 the state SHALL become InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k(r-1)), then counter decrements.
REQ-019 In RUN, when r=1 (final round, no InvMixColumns):
  - plaintext <= InvSubBytes(InvShiftRows(state)) ^ k0; keyoutput <= k0.
  - done <= 1; go to IDLE.
REQ-020 Latency SHALL be exactly 11 clock edges from the accept edge to the edge that raises done; busy SHALL be high for exactly 10 cycles.
REQ-021 done SHALL be high for exactly one cycle, the cycle in which busy is already 0.
REQ-022 start while busy=1 SHALL be ignored, with no effect on state, counter or outputs.
REQ-023 start during the done cycle SHALL be accepted (back-to-back operation), and plaintext/keyoutput SHALL hold until the next final round.
REQ-024 ciphertext and lastkey SHALL be sampled only on the accept edge; later changes SHALL have no effect.
REQ-025 InvSubBytes SHALL use 16 instances of the team's byte inverse S-box; SubWord SHALL use 4 forward S-box byte lookups.
REQ-026 InvMixColumns SHALL use GF(2^8) coefficients 0e,0b,0d,09 with reduction polynomial 0x11b.

Reset
REQ-027 When reset=1 at an edge, the block SHALL force IDLE, counter=0, busy=0, done=0, plaintext=0, keyoutput=0, and clear the internal state and key registers.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; the next start after reset deasserts SHALL behave normally.

Verification
REQ-030 FIPS-197 Appendix B: lastkey=d014f9a8c9ee2589e13f0cc8b6630ca6, ciphertext=3925841d02dc09fbdc118597196a0b32, start 1 cycle -> done 11 edges later, plaintext=3243f6a8885a308d313198a2e0370734, keyoutput=2b7e151628aed2a6abf7158809cf4f3c.
REQ-031 FIPS-197 Appendix C.1: lastkey=13111d7fe3944a17f307a78b4d2b30c5, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff, keyoutput=000102030405060708090a0b0c0d0e0f.
REQ-032 Back-to-back: B vector, then start in its done cycle with the C.1 vector -> two done pulses 11 cycles apart, both results correct, B result held for 11 cycles.
REQ-033 Busy interference: start=1 held for all 10 busy cycles with ciphertext changing each cycle -> exactly one done with the original result.
REQ-034 Reset at busy cycle 5 -> no done, all outputs 0 next cycle; a fresh C.1 start then yields the correct C.1 result.

Source files
------------

// File: rtl/aes_inv_rounds.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// recovered on the fly by running the key schedule backwards from the round-10 key.
package aes_inv_rounds_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

endpackage

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_inv_rounds_pkg::*;
    logic [7:0] w_inv;
    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_inv_rounds_pkg::*;
    logic [7:0] w_aff;
    assign w_aff  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
                  ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
    assign o_byte = gf_inv(w_aff);
endmodule

// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | one inverse round per edge, r_cnt = current round (10..1)
module aes_inv_rounds (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] lastkey,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext,
    output logic [127:0] keyoutput
);
    import aes_inv_rounds_pkg::*;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       r_fsm;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_pt;
    logic [127:0] r_kout;

    logic [127:0] w_shift, w_sub, w_addk, w_mix, w_key_prev;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3, w_rot, w_subw;
    logic [7:0]   w_rcon;

    assign busy      = r_busy;
    assign done      = r_done;
    assign plaintext = r_pt;
    assign keyoutput = r_kout;

    // byte n = row + 4*col sits at bits [127-8n -: 8]; row r rotates right by r
    always_comb begin
        w_shift = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_shift[127-8*(r+4*c) -: 8] = r_state[127-8*(r+4*((c-r)&3)) -: 8];
    end

    for (genvar g = 0; g < 16; g++) begin : g_isb
        aes_inv_sbox u_isb (.i_byte(w_shift[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
    end

    always_comb begin
        case (r_cnt)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_k3 = r_key[31:0]  ^ r_key[63:32];
    assign w_k2 = r_key[63:32] ^ r_key[95:64];
    assign w_k1 = r_key[95:64] ^ r_key[127:96];
    assign w_rot = {w_k3[23:0], w_k3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sb
        aes_sbox u_sb (.i_byte(w_rot[8*g +: 8]), .o_byte(w_subw[8*g +: 8]));
    end

    assign w_k0       = r_key[127:96] ^ w_subw ^ {w_rcon, 24'h000000};
    assign w_key_prev = {w_k0, w_k1, w_k2, w_k3};
    assign w_addk     = w_sub ^ w_key_prev;

    always_comb begin
        w_mix = '0;
        for (int c = 0; c < 4; c++)
            w_mix[127-32*c -: 32] = inv_mix_col(w_addk[127-32*c -: 32]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= 4'd0;
            r_state <= '0;
            r_key   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pt    <= '0;
            r_kout  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_state <= ciphertext ^ lastkey;
                        r_key   <= lastkey;
                        r_cnt   <= 4'd10;
                        r_busy  <= 1'b1;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_key <= w_key_prev;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_pt   <= w_addk;
                        r_kout <= w_key_prev;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_fsm  <= S_IDLE;
                    end else begin
                        r_state <= w_mix;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_rounds.sv
// Directed bench for aes_inv_rounds using the FIPS-197 Appendix B and C.1 vectors.
module tb_aes_inv_rounds;

    localparam logic [127:0] B_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_K0  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] lastkey;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;
    logic [127:0] keyoutput;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    aes_inv_rounds dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ciphertext (ciphertext),
        .lastkey    (lastkey),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext),
        .keyoutput  (keyoutput)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // steps until done is seen or the budget runs out; edges counts the steps taken
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!done && edges < 40);
    endtask

    task automatic run_one(input string tag, input logic [127:0] ct, input logic [127:0] lk,
                           input logic [127:0] exp_pt, input logic [127:0] exp_k0);
        int  edges;
        int  busy_cyc;
        bit  got;
        start = 1'b1; ciphertext = ct; lastkey = lk;
        step();
        start = 1'b0; ciphertext = ~ct; lastkey = ~lk;
        edges = 1; busy_cyc = 0; got = 1'b0;
        while (!got && edges < 40) begin
            if (busy) busy_cyc++;
            step();
            edges++;
            if (done) got = 1'b1;
        end
        check({tag, "_latency"}, edges, 11);
        check({tag, "_busy_cycles"}, busy_cyc, 10);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_plaintext"}, plaintext, exp_pt);
        check({tag, "_keyoutput"}, keyoutput, exp_k0);
        step();
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int edges;
        int gap;
        int held;
        int dones;

        reset = 1'b1; start = 1'b0; ciphertext = '0; lastkey = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plaintext", plaintext, 0);
        check("rst_keyoutput", keyoutput, 0);

        run_one("vecB", B_CT, B_KEY, B_PT, B_K0);
        run_one("vecC", C_CT, C_KEY, C_PT, C_K0);

        // back-to-back: second start lands in the first done cycle
        start = 1'b1; ciphertext = B_CT; lastkey = B_KEY;
        step();
        start = 1'b0;
        wait_done(edges);
        check("b2b_first_edges", edges, 10);
        check("b2b_first_pt", plaintext, B_PT);
        start = 1'b1; ciphertext = C_CT; lastkey = C_KEY;
        gap = 0; held = 0;
        do begin
            if (plaintext === B_PT) held++;
            step();
            start = 1'b0;
            gap++;
        end while (!done && gap < 40);
        check("b2b_gap", gap, 11);
        check("b2b_held", held, 11);
        check("b2b_second_pt", plaintext, C_PT);
        check("b2b_second_key", keyoutput, C_K0);
        step();

        // start held through all busy cycles with changing inputs
        start = 1'b1; ciphertext = B_CT; lastkey = B_KEY;
        step();
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            ciphertext = {4{32'(i + 1) * 32'h9e3779b9}};
            lastkey    = {4{32'(i + 7) * 32'h7f4a7c15}};
            step();
            if (done) dones++;
        end
        start = 1'b0;
        check("hold_done_at_end", done, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) dones++;
        end
        check("hold_done_count", dones, 1);
        check("hold_pt", plaintext, B_PT);
        check("hold_key", keyoutput, B_K0);

        // reset at busy cycle 5, with start asserted alongside it
        start = 1'b1; ciphertext = B_CT; lastkey = B_KEY;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_busy_before", busy, 1);
        reset = 1'b1; start = 1'b1; ciphertext = C_CT; lastkey = C_KEY;
        step();
        reset = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pt", plaintext, 0);
        check("abort_key", keyoutput, 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done || busy) dones++;
        end
        check("abort_quiet", dones, 0);
        run_one("vecC_after_rst", C_CT, C_KEY, C_PT, C_K0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
